countdown_timer: RTL

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/timer_pkg.sv | 22 ++
 rtl/countdown_timer_if.sv | 23 ++
 rtl/countdown_timer_rise_detect.sv | 23 ++
 rtl/countdown_timer.sv | 113 +++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the MM:SS BCD countdown timer.
// Digits are packed {min_tens, min_units, sec_tens, sec_units}.
package timer_pkg;

    localparam int          DIGIT_W      = 4;
    localparam logic [3:0]  DIGIT_MAX    = 4'd9;
    localparam logic [3:0]  SEC_TENS_MAX = 4'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Rejects any non-BCD nibble and seconds-tens above 5.
    function automatic logic bcd_valid(input logic [4*DIGIT_W-1:0] v);
        return (v[15:12] <= DIGIT_MAX) && (v[11:8] <= DIGIT_MAX) &&
               (v[7:4]   <= SEC_TENS_MAX) && (v[3:0] <= DIGIT_MAX);
    endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Command/status bundle between the timer and its controller.
interface countdown_timer_if;
    logic        tick_in;
    logic        start;
    logic        stop;
    logic        load;
    logic [15:0] load_bcd;
    logic [15:0] digits;
    logic        running;
    logic        done;
    logic        done_pulse;
    logic        load_err;

    modport master (
        output tick_in, start, stop, load, load_bcd,
        input  digits, running, done, done_pulse, load_err
    );

    modport slave (
        input  tick_in, start, stop, load, load_bcd,
        output digits, running, done, done_pulse, load_err
    );
endinterface

// File: rtl/countdown_timer_rise_detect.sv
// Registers a slow input into the clk domain and flags its rising edge
// for one cycle, one cycle after the input rises.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic pulse
);
    logic in_q;
    logic in_dly_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q     <= 1'b0;
            in_dly_q <= 1'b0;
        end else begin
            in_q     <= in;
            in_dly_q <= in_q;
        end
    end

    assign pulse = in_q & ~in_dly_q;
endmodule

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer with IDLE/RUN/PAUSE/DONE control and
// validated loads; every output is registered.
module countdown_timer
    import timer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    countdown_timer_if.slave  bus
);
    state_e      state_q, state_d;
    logic [15:0] digits_q, digits_d;
    logic        running_q, running_d;
    logic        done_q, done_d;
    logic        done_pulse_q, done_pulse_d;
    logic        load_err_q, load_err_d;
    logic        tick_evt;
    logic [15:0] dec_val;

    rise_detect u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (bus.tick_in),
        .pulse (tick_evt)
    );

    // Only ever applied to a non-zero count, so min_tens never underflows.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [3:0] mt, mu, st, su;
        {mt, mu, st, su} = v;
        if (su != 4'd0) begin
            su = su - 4'd1;
        end else begin
            su = DIGIT_MAX;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = SEC_TENS_MAX;
                if (mu != 4'd0) begin
                    mu = mu - 4'd1;
                end else begin
                    mu = DIGIT_MAX;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mu, st, su};
    endfunction

    assign dec_val = bcd_dec(digits_q);

    always_comb begin
        state_d    = state_q;
        digits_d   = digits_q;
        load_err_d = 1'b0;

        // Load outranks stop/start everywhere except RUN, where it is dropped.
        if (bus.load && (state_q != RUN)) begin
            if (bcd_valid(bus.load_bcd)) begin
                digits_d = bus.load_bcd;
                state_d  = (state_q == DONE) ? IDLE : state_q;
            end else begin
                load_err_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start && (digits_q != 16'h0000)) state_d = RUN;
                end
                RUN: begin
                    if (bus.stop) begin
                        state_d = PAUSE;
                    end else if (tick_evt) begin
                        digits_d = dec_val;
                        if (dec_val == 16'h0000) state_d = DONE;
                    end
                end
                PAUSE: begin
                    if (!bus.stop && bus.start) state_d = RUN;
                end
                DONE: ;
                default: state_d = IDLE;
            endcase
        end

        running_d    = (state_d == RUN);
        done_d       = (state_d == DONE);
        done_pulse_d = (state_d == DONE) && (state_q != DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            digits_q     <= 16'h0000;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            done_pulse_q <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            digits_q     <= digits_d;
            running_q    <= running_d;
            done_q       <= done_d;
            done_pulse_q <= done_pulse_d;
            load_err_q   <= load_err_d;
        end
    end

    assign bus.digits     = digits_q;
    assign bus.running    = running_q;
    assign bus.done       = done_q;
    assign bus.done_pulse = done_pulse_q;
    assign bus.load_err   = load_err_q;
endmodule
